// File: rtl/conv3x3_frame_sequencer.sv
// Frame sequencer for a 3x3 convolution datapath: walks every valid window of an
// IMG_H x IMG_W image, gathers its 9 pixels, runs the datapath and streams results.
module conv3x3_frame_sequencer #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [71:0]       win_pix,
    output logic              conv_start,
    input  logic              conv_done,
    input  logic [23:0]       conv_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [23:0]       out_data,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col
);

    typedef enum logic [2:0] {IDLE, FETCH, LAST, CONV, OUT, DONE} state_t;

    state_t      state;
    logic [7:0]  r, c;
    logic [3:0]  k;
    logic [1:0]  kr, kc;

    logic [7:0]        next_r, next_c;
    logic              last_window;
    logic [1:0]        next_kr, next_kc;
    logic [ADDR_W-1:0] fetch_addr, start_addr;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] row, input logic [7:0] col,
                                                   input logic [1:0] dr, input logic [1:0] dc);
        logic [15:0] a;
        a = (16'(row) + 16'(dr)) * 16'(IMG_W) + 16'(col) + 16'(dc);
        return a[ADDR_W-1:0];
    endfunction

    // Window advance: step right along a row, then wrap to the next row of windows.
    always_comb begin
        next_r      = r;
        next_c      = c;
        last_window = 1'b0;
        if (c < 8'(IMG_W - 3)) begin
            next_c = c + 8'd1;
        end else if (r < 8'(IMG_H - 3)) begin
            next_c = 8'd0;
            next_r = r + 8'd1;
        end else begin
            last_window = 1'b1;
        end
    end

    always_comb begin
        next_kr = kr;
        next_kc = kc + 2'd1;
        if (kc == 2'd2) begin
            next_kc = 2'd0;
            next_kr = kr + 2'd1;
        end
        fetch_addr = pix_addr(r, c, next_kr, next_kc);
        start_addr = pix_addr(next_r, next_c, 2'd0, 2'd0);
    end

    // RAM read data lags the address by one cycle, so slot k-1 is written during fetch k.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            r          <= '0;
            c          <= '0;
            k          <= '0;
            kr         <= '0;
            kc         <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            win_pix    <= '0;
            conv_start <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        r        <= '0;
                        c        <= '0;
                        k        <= '0;
                        kr       <= '0;
                        kc       <= '0;
                        mem_en   <= 1'b1;
                        mem_addr <= '0;
                    end
                end
                FETCH: begin
                    if (k != 4'd0) begin
                        win_pix[{k - 4'd1, 3'd0} +: 8] <= mem_data;
                    end
                    if (k == 4'd8) begin
                        mem_en <= 1'b0;
                        state  <= LAST;
                    end else begin
                        k        <= k + 4'd1;
                        kr       <= next_kr;
                        kc       <= next_kc;
                        mem_addr <= fetch_addr;
                    end
                end
                LAST: begin
                    win_pix[71:64] <= mem_data;
                    conv_start     <= 1'b1;
                    state          <= CONV;
                end
                CONV: begin
                    if (conv_done) begin
                        out_data   <= conv_result;
                        out_row    <= r;
                        out_col    <= c;
                        conv_start <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_window) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            r        <= next_r;
                            c        <= next_c;
                            k        <= '0;
                            kr       <= '0;
                            kc       <= '0;
                            mem_en   <= 1'b1;
                            mem_addr <= start_addr;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_frame_sequencer.sv
// Bench for conv3x3_frame_sequencer: RAM and datapath models plus a result scoreboard.
module tb_conv3x3_frame_sequencer;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = 6;
    localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              go = 1'b0;
    logic              busy, frame_done, mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data = '0;
    logic [71:0]       win_pix;
    logic              conv_start;
    logic              conv_done = 1'b0;
    logic [23:0]       conv_result = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [23:0]       out_data;
    logic [7:0]        out_row, out_col;

    typedef struct {
        logic [7:0]  row;
        logic [7:0]  col;
        logic [23:0] data;
        logic [71:0] win;
    } exp_t;

    logic [7:0] ram [IMG_W*IMG_H];
    logic [7:0] weight [9];
    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc_count = 0;
    int         fetch_idx = 0;
    int         win_start = 0;
    int         mon_w, mon_k, mon_r, mon_c;

    conv3x3_frame_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .frame_done(frame_done),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data), .win_pix(win_pix),
        .conv_start(conv_start), .conv_done(conv_done), .conv_result(conv_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    function automatic logic [23:0] dp_sum(input logic [71:0] w);
        logic [23:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) s += 24'(w[8*i +: 8]) * 24'(weight[i]);
        return s;
    endfunction

    // Synchronous RAM and a one-cycle registered multiply-accumulate datapath.
    always @(posedge clk) begin
        if (mem_en) mem_data <= ram[mem_addr];
        conv_done   <= conv_start;
        conv_result <= dp_sum(win_pix);
    end

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every fetch is checked against the raster window order, 9 addresses per window back to back.
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            mon_w = fetch_idx / 9;
            mon_k = fetch_idx % 9;
            mon_r = mon_w / (IMG_W - 2);
            mon_c = mon_w % (IMG_W - 2);
            checkOutput("mem_addr", 72'(mem_addr), 72'((mon_r + mon_k / 3) * IMG_W + mon_c + mon_k % 3));
            if (mon_k == 0) win_start = cyc_count;
            else checkOutput("addr_consecutive", 72'(cyc_count - win_start), 72'(mon_k));
            fetch_idx++;
        end
    end

    task automatic applyStimulus(input bit all_max);
        exp_t e;
        for (int a = 0; a < IMG_W*IMG_H; a++) ram[a] = all_max ? 8'd255 : 8'(a);
        for (int i = 0; i < 9; i++) weight[i] = all_max ? 8'd255 : 8'd1;
        exp_q.delete();
        for (int r = 0; r < IMG_H - 2; r++) begin
            for (int c = 0; c < IMG_W - 2; c++) begin
                e.row  = 8'(r);
                e.col  = 8'(c);
                e.data = '0;
                e.win  = '0;
                for (int i = 0; i < 9; i++) begin
                    e.win[8*i +: 8] = ram[(r + i / 3) * IMG_W + c + i % 3];
                    e.data += 24'(ram[(r + i / 3) * IMG_W + c + i % 3]) * 24'(weight[i]);
                end
                exp_q.push_back(e);
            end
        end
        fetch_idx = 0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_busy", 72'(busy), 72'(0));
        checkOutput("rst_frame_done", 72'(frame_done), 72'(0));
        checkOutput("rst_mem_en", 72'(mem_en), 72'(0));
        checkOutput("rst_mem_addr", 72'(mem_addr), 72'(0));
        checkOutput("rst_win_pix", win_pix, 72'(0));
        checkOutput("rst_conv_start", 72'(conv_start), 72'(0));
        checkOutput("rst_out_valid", 72'(out_valid), 72'(0));
        checkOutput("rst_out_data", 72'(out_data), 72'(0));
        checkOutput("rst_out_row", 72'(out_row), 72'(0));
        checkOutput("rst_out_col", 72'(out_col), 72'(0));
    endtask

    task automatic runFrame(input bit stall, input bit go_mid);
        int   n_out = 0;
        int   n_done = 0;
        int   hs_cyc = -10;
        bit   stall_pending;
        bit   finished = 0;
        exp_t e;
        stall_pending = stall;
        out_ready = 1'b1;
        for (int i = 0; i < 3000 && !finished; i++) begin
            @(negedge clk);
            go = go_mid && (i == 100);
            if (out_valid) begin
                if (stall_pending && exp_q.size() > 0) begin
                    stall_pending = 0;
                    out_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        checkOutput("stall_out_valid", 72'(out_valid), 72'(1));
                        checkOutput("stall_out_data", 72'(out_data), 72'(exp_q[0].data));
                        checkOutput("stall_win_pix", win_pix, exp_q[0].win);
                        checkOutput("stall_mem_en", 72'(mem_en), 72'(0));
                        checkOutput("stall_conv_start", 72'(conv_start), 72'(0));
                    end
                    out_ready = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    checkOutput("extra_output", 72'(1), 72'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", 72'(out_data), 72'(e.data));
                    checkOutput("out_row", 72'(out_row), 72'(e.row));
                    checkOutput("out_col", 72'(out_col), 72'(e.col));
                    checkOutput("win_pix", win_pix, e.win);
                    checkOutput("busy_in_out", 72'(busy), 72'(1));
                end
                n_out++;
                hs_cyc = cyc_count;
            end
            if (frame_done) begin
                n_done++;
                checkOutput("frame_done_timing", 72'(cyc_count - hs_cyc), 72'(1));
                finished = 1;
            end
        end
        go = 1'b0;
        checkOutput("frame_finished", 72'(finished), 72'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_done) n_done++;
            if (out_valid) n_out++;
        end
        checkOutput("outputs_per_frame", 72'(n_out), 72'(NWIN));
        checkOutput("frame_done_count", 72'(n_done), 72'(1));
        checkOutput("busy_after_frame", 72'(busy), 72'(0));
        checkOutput("queue_drained", 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        checkResetState();
        reset = 1'b0;

        $display("[TB] ramp image, unit weights, go pulsed mid-frame");
        applyStimulus(1'b0);
        runFrame(1'b0, 1'b1);

        $display("[TB] saturated image and weights with output backpressure");
        applyStimulus(1'b1);
        runFrame(1'b1, 1'b0);

        $display("[TB] reset during fetch of the first window, then a fresh frame");
        applyStimulus(1'b0);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (mem_en && mem_addr == ADDR_W'(IMG_W + 1)) hit = 1;
        end
        checkOutput("reached_fetch_k4", 72'(hit), 72'(1));
        reset = 1'b1;
        @(negedge clk);
        checkResetState();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_frame_done", 72'(frame_done), 72'(0));
        checkOutput("post_reset_conv_start", 72'(conv_start), 72'(0));
        checkOutput("post_reset_busy", 72'(busy), 72'(0));
        applyStimulus(1'b0);
        runFrame(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
